if_id_skid_latch: RTL

Parametrised successor to the plain IF/ID pipeline latch. It carries {npc, instr} from fetch to decode through a valid/ready handshake with a 2-entry skid buffer. Decode back-pressure therefore never needs a combinational path to fetch. It also supports a synchronous flush that inserts a bubble for branch/jump redirects.

---
 rtl/if_id_skid_latch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/if_id_skid_latch.sv
// rtl/if_id_skid_latch.sv - IF/ID pipeline latch with 2-entry skid buffer and flush bubble
// Carries {npc, instr} from fetch to decode; in_ready is registered so decode stalls never reach fetch combinationally.
module if_id_skid_latch #(
  parameter int                 NPC_W     = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NPC_W-1:0]   in_npc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NPC_W-1:0]   out_npc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_in_ready;
  logic [NPC_W-1:0]   r_main_npc;
  logic [INSTR_W-1:0] r_main_instr;
  logic [NPC_W-1:0]   r_skid_npc;
  logic [INSTR_W-1:0] r_skid_instr;

  logic w_accept;
  logic w_xfer;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_load_bubble;
  logic w_clr_skid;

  assign out_valid = (r_state != S_EMPTY);
  assign in_ready  = r_in_ready;
  assign out_npc   = r_main_npc;
  assign out_instr = r_main_instr;
  assign count     = r_state;

  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = out_valid & out_ready;

  always_comb begin
    w_next           = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_load_bubble    = 1'b0;
    w_clr_skid       = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_next         = S_BUSY;
          w_load_main_in = 1'b1;
        end
      end
      S_BUSY: begin
        if (w_accept && w_xfer) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_next      = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_xfer) begin
          w_next        = S_EMPTY;
          w_load_bubble = 1'b1;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only a drain can happen
        if (w_xfer) begin
          w_next           = S_BUSY;
          w_load_main_skid = 1'b1;
          w_clr_skid       = 1'b1;
        end
      end
      default: begin
        w_next        = S_EMPTY;
        w_load_bubble = 1'b1;
        w_clr_skid    = 1'b1;
      end
    endcase
    // Redirect wins over everything: drop held and incoming entries alike
    if (flush) begin
      w_next           = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      w_load_bubble    = 1'b1;
      w_clr_skid       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_npc   <= '0;
      r_main_instr <= NOP_INSTR;
    end else if (w_load_bubble) begin
      r_main_npc   <= '0;
      r_main_instr <= NOP_INSTR;
    end else if (w_load_main_skid) begin
      r_main_npc   <= r_skid_npc;
      r_main_instr <= r_skid_instr;
    end else if (w_load_main_in) begin
      r_main_npc   <= in_npc;
      r_main_instr <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_npc   <= '0;
      r_skid_instr <= '0;
    end else if (w_clr_skid) begin
      r_skid_npc   <= '0;
      r_skid_instr <= '0;
    end else if (w_load_skid) begin
      r_skid_npc   <= in_npc;
      r_skid_instr <= in_instr;
    end
  end

endmodule
